// File: rtl/scs8hd_o2nai_pkg.sv
// Shared limits, occupancy-width helper and per-stage record for the o2nai pipeline.
// Optional power-pin build: SCS8HD_PG_PIN_EN (see scs8hd_o2nai_pipe).
package scs8hd_o2nai_pkg;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 32;
    localparam int MIN_NA    = 1;
    localparam int MAX_NA    = 4;
    localparam int MIN_DEPTH = 1;
    localparam int MAX_DEPTH = 8;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // One pipeline stage as seen by a checker; dat is sized for the widest build.
    typedef struct packed {
        logic                 vld;
        logic [MAX_WIDTH-1:0] dat;
    } stage_rec_t;

endpackage

// File: rtl/scs8hd_o2nai_stage.sv
// One valid/data pipeline register: loads when adv_i is high, holds otherwise.
// Data is not gated by valid, so a bubble may carry don't-care data.
module scs8hd_o2nai_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             adv_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (adv_i) begin
            vld_d = vld_i;
            dat_d = dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/scs8hd_o2nai_pipe.sv
// WIDTH-channel OR-AND(-invert) slice behind a DEPTH-stage valid/ready pipeline with occupancy.
// Define SCS8HD_PG_PIN_EN to add vpwr/vgnd/vpb/vnb supply pins with power-good gating.
module scs8hd_o2nai_pipe
    import scs8hd_o2nai_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NA     = 2,
    parameter int DEPTH  = 2,
    parameter int INVERT = 1
) (
    input  logic                          CLK,
    input  logic                          RESETB,
    input  logic [WIDTH*NA-1:0]           A,
    input  logic [WIDTH-1:0]              B1,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    output logic [WIDTH-1:0]              Y,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
`ifdef SCS8HD_PG_PIN_EN
    input  logic                          vpwr,
    input  logic                          vgnd,
    input  logic                          vpb,
    input  logic                          vnb,
`endif
    output logic [occ_width(DEPTH)-1:0]   OCC
);

    localparam int OW = occ_width(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] d0;
    logic             clr_n;
    logic             accept;
    logic             emit;
    logic [OW-1:0]    occ_q, occ_d;

`ifdef SCS8HD_PG_PIN_EN
    // Supply checks are 4-state so a floating rail counts as power-bad.
    logic pg_good;
    assign pg_good = (vpwr === 1'b1) && (vgnd === 1'b0);
    assign clr_n   = RESETB & pg_good;
`else
    assign clr_n   = RESETB;
`endif

    always_comb begin
        f = '0;
        for (int c = 0; c < WIDTH; c++) begin
            f[c] = B1[c] & (|A[c*NA +: NA]);
        end
    end

    assign d0 = (INVERT != 0) ? ~f : f;

    // Ready ripples back combinationally, so a bubble anywhere is filled this cycle.
    assign adv[DEPTH-1] = OUT_READY | ~vld[DEPTH-1];

    for (genvar s = 0; s < DEPTH - 1; s++) begin : g_adv
        assign adv[s] = adv[s+1] | ~vld[s];
    end

    assign accept = IN_VALID & adv[0];
    assign emit   = vld[DEPTH-1] & OUT_READY;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        if (s == 0) begin : g_first
            scs8hd_o2nai_stage #(.WIDTH(WIDTH)) u_stage (
                .clk_i   (CLK),
                .rst_n_i (clr_n),
                .adv_i   (adv[s]),
                .vld_i   (accept),
                .dat_i   (d0),
                .vld_o   (vld[s]),
                .dat_o   (dat[s])
            );
        end else begin : g_rest
            scs8hd_o2nai_stage #(.WIDTH(WIDTH)) u_stage (
                .clk_i   (CLK),
                .rst_n_i (clr_n),
                .adv_i   (adv[s]),
                .vld_i   (vld[s-1]),
                .dat_i   (dat[s-1]),
                .vld_o   (vld[s]),
                .dat_o   (dat[s])
            );
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (accept && !emit) begin
            occ_d = occ_q + 1'b1;
        end else if (emit && !accept) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef SCS8HD_PG_PIN_EN
    assign IN_READY  = pg_good ? adv[0]         : 1'bx;
    assign Y         = pg_good ? dat[DEPTH-1]   : {WIDTH{1'bx}};
    assign OUT_VALID = pg_good ? vld[DEPTH-1]   : 1'bx;
    assign OCC       = pg_good ? occ_q          : {OW{1'bx}};
`else
    assign IN_READY  = adv[0];
    assign Y         = dat[DEPTH-1];
    assign OUT_VALID = vld[DEPTH-1];
    assign OCC       = occ_q;
`endif

    a_in_known: assert property (@(posedge CLK) disable iff (!RESETB)
        IN_VALID |-> !$isunknown({A, B1}));

endmodule

// File: tb/tb_scs8hd_o2nai_pipe.sv
// Directed bench for scs8hd_o2nai_pipe: reset, latency, truth table, backpressure,
// full-rate streaming and mid-run reset, with an OAI and an OA instance side by side.
module tb_scs8hd_o2nai_pipe;

  logic       clk = 1'b0;
  logic       RESETB;
  logic [7:0] A;
  logic [3:0] B1;
  logic       IN_VALID;
  logic       OUT_READY;
  logic       IN_READY, OUT_VALID;
  logic [3:0] Y;
  logic [1:0] OCC;
  logic       IN_READY_oa, OUT_VALID_oa;
  logic [3:0] Y_oa;
  logic [1:0] OCC_oa;
`ifdef SCS8HD_PG_PIN_EN
  logic vpwr = 1'b1, vgnd = 1'b0, vpb = 1'b1, vnb = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int n_out = 0;
  int mark;
  logic [3:0] exp_q[$];
  logic [3:0] exp_e;
  logic [7:0] va[8];
  logic [3:0] vb[8];
  logic [3:0] ve[8];
  logic [7:0] tt;

  scs8hd_o2nai_pipe #(.WIDTH(4), .NA(2), .DEPTH(2), .INVERT(1)) dut (
    .CLK(clk), .RESETB(RESETB), .A(A), .B1(B1), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .Y(Y), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
`ifdef SCS8HD_PG_PIN_EN
    .vpwr(vpwr), .vgnd(vgnd), .vpb(vpb), .vnb(vnb),
`endif
    .OCC(OCC)
  );

  scs8hd_o2nai_pipe #(.WIDTH(4), .NA(2), .DEPTH(2), .INVERT(0)) dut_oa (
    .CLK(clk), .RESETB(RESETB), .A(A), .B1(B1), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY_oa), .Y(Y_oa), .OUT_VALID(OUT_VALID_oa), .OUT_READY(OUT_READY),
`ifdef SCS8HD_PG_PIN_EN
    .vpwr(vpwr), .vgnd(vgnd), .vpb(vpb), .vnb(vnb),
`endif
    .OCC(OCC_oa)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer one vector; expectation is queued at the cycle it is accepted
  task automatic send(input logic [7:0] a, input logic [3:0] b, input logic [3:0] e);
    bit done;
    done = 1'b0;
    A = a;
    B1 = b;
    IN_VALID = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (IN_READY) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    IN_VALID = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  // scoreboard: handshake seen at negedge completes on the next rising edge
  always @(negedge clk) begin
    if (RESETB && OUT_VALID === 1'b1 && OUT_READY) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("y", Y, exp_e);
        check("y_oa", Y_oa, ~exp_e & 4'hF);
        check("oa_valid", OUT_VALID_oa, 1);
      end
    end
  end

  initial begin
    va[0] = 8'h1B; vb[0] = 4'hF; ve[0] = 4'h8;
    va[1] = 8'h00; vb[1] = 4'hF; ve[1] = 4'hF;
    va[2] = 8'hFF; vb[2] = 4'hF; ve[2] = 4'h0;
    va[3] = 8'hFF; vb[3] = 4'h0; ve[3] = 4'hF;
    va[4] = 8'h55; vb[4] = 4'hA; ve[4] = 4'h5;
    va[5] = 8'hAA; vb[5] = 4'h5; ve[5] = 4'hA;
    va[6] = 8'hC3; vb[6] = 4'hF; ve[6] = 4'h6;
    va[7] = 8'h30; vb[7] = 4'hC; ve[7] = 4'hB;
    // channel-0 OAI result indexed by {B1, A2, A1}
    tt = 8'b0001_1111;

    RESETB = 1'b0; OUT_READY = 1'b1; IN_VALID = 1'b0; A = '0; B1 = '0;
    repeat (2) tick();
    check("rst_y", Y, 0);
    check("rst_ovalid", OUT_VALID, 0);
    check("rst_occ", OCC, 0);
    check("rst_in_ready", IN_READY, 1);
    check("rst_occ_oa", OCC_oa, 0);
    check("rst_in_ready_oa", IN_READY_oa, 1);
    @(negedge clk);
    RESETB = 1'b1;
    tick();

    // latency
    send(va[0], vb[0], ve[0]);
    check("lat_occ1", OCC, 1);
    check("lat_ovalid1", OUT_VALID, 0);
    tick();
    check("lat_ovalid2", OUT_VALID, 1);
    check("lat_y", Y, 4'h8);
    check("lat_occ2", OCC, 1);
    tick();
    check("lat_occ3", OCC, 0);
    check("lat_ovalid3", OUT_VALID, 0);

    // truth table on channel 0
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      send({6'b0, idx[1:0]}, {3'b0, idx[2]}, {3'b111, tt[i]});
    end
    repeat (3) tick();

    // directed vectors back to back
    for (int i = 0; i < 8; i++) send(va[i], vb[i], ve[i]);
    repeat (3) tick();
    check("dir_drained", OCC, 0);

    // backpressure
    OUT_READY = 1'b0;
    send(va[0], vb[0], ve[0]);
    send(va[1], vb[1], ve[1]);
    check("bp_occ", OCC, 2);
    check("bp_rdy", IN_READY, 0);
    A = va[2]; B1 = vb[2]; IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_rdy", IN_READY, 0);
      check("bp_hold_occ", OCC, 2);
      check("bp_hold_ovalid", OUT_VALID, 1);
    end
    IN_VALID = 1'b0;
    mark = n_out;
    OUT_READY = 1'b1;
    send(va[2], vb[2], ve[2]);
    send(va[3], vb[3], ve[3]);
    send(va[4], vb[4], ve[4]);
    repeat (4) tick();
    check("bp_count", n_out - mark, 5);
    check("bp_empty", OCC, 0);

    // full pipe, simultaneous accept and emit
    OUT_READY = 1'b0;
    send(va[5], vb[5], ve[5]);
    send(va[6], vb[6], ve[6]);
    OUT_READY = 1'b1;
    mark = n_out;
    for (int j = 0; j < 10; j++) begin
      send(va[j % 8], vb[j % 8], ve[j % 8]);
      check("sim_occ", OCC, 2);
    end
    check("sim_count", n_out - mark, 10);
    repeat (3) tick();
    check("sim_drained", OCC, 0);

    // asynchronous reset mid-run
    OUT_READY = 1'b0;
    send(va[6], vb[6], ve[6]);
    send(va[7], vb[7], ve[7]);
    check("mr_occ_pre", OCC, 2);
    #3;
    RESETB = 1'b0;
    #1;
    check("mr_ovalid", OUT_VALID, 0);
    check("mr_occ", OCC, 0);
    check("mr_y", Y, 0);
    check("mr_in_ready", IN_READY, 1);
    exp_q.delete();
    #2;
    RESETB = 1'b1;
    OUT_READY = 1'b1;
    repeat (4) tick();
    check("mr_quiet_ovalid", OUT_VALID, 0);
    check("mr_quiet_occ", OCC, 0);
    send(va[4], vb[4], ve[4]);
    repeat (3) tick();

`ifdef SCS8HD_PG_PIN_EN
    send(va[0], vb[0], ve[0]);
    vpwr = 1'b0;
    #1;
    check("pg_y_x", 32'($isunknown(Y)), 1);
    check("pg_occ_x", 32'($isunknown(OCC)), 1);
    repeat (3) tick();
    exp_q.delete();
    vpwr = 1'b1;
    tick();
    check("pg_occ", OCC, 0);
    check("pg_ovalid", OUT_VALID, 0);
    send(va[1], vb[1], ve[1]);
    repeat (3) tick();
`endif

    check("end_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
